// File: rtl/pkt_router_pkg.sv
// Shared packet-format constants and types for the 4-port packet router.
// Packet layout: [VALID_BIT] valid, [DST_MSB:DST_LSB] destination port, rest payload.
package pkt_router_pkg;

  localparam int PORTS     = 4;
  localparam int PKTW      = 10;
  localparam int VALID_BIT = PKTW;
  localparam int DST_MSB   = PKTW - 1;
  localparam int DST_LSB   = PKTW - 2;
  localparam int PAYW      = PKTW - 2;

  typedef logic [PKTW:0] pkt_t;
  typedef logic [1:0]    port_t;

  function automatic port_t dst_of(input pkt_t pkt);
    return pkt[DST_MSB:DST_LSB];
  endfunction

endpackage

// File: rtl/pkt_router_fifo.sv
// Single-clock packet FIFO with an extra pointer bit to tell full from empty.
// The parent guarantees pop only when non-empty and push only when not full or popping.
module pkt_fifo
  import pkt_router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  pkt_t data,
  output pkt_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  pkt_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which slots are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/pkt_router.sv
// 4x4 packet router: per-input FIFOs, per-output round-robin arbitration,
// registered outputs (two-cycle latency when uncontended) and sticky drop flags.
module pkt_router
  import pkt_router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0][PKTW:0]   in_pkt,
  output logic [PORTS-1:0][PKTW:0]   out_pkt,
  output logic [PORTS-1:0]           ovf
);

  pkt_t                     head [PORTS];
  logic [PORTS-1:0]         full;
  logic [PORTS-1:0]         empty;
  logic [PORTS-1:0]         push;
  logic [PORTS-1:0]         pop;
  logic [PORTS-1:0]         drop;
  logic [PORTS-1:0][1:0]    rr;
  logic [PORTS-1:0][1:0]    rr_next;
  logic [PORTS-1:0][PKTW:0] out_next;

  for (genvar k = 0; k < PORTS; k++) begin : g_in
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign push[k] = in_pkt[k][VALID_BIT] && (!full[k] || pop[k]);
    assign drop[k] = in_pkt[k][VALID_BIT] &&   full[k] && !pop[k];

    pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .data  (in_pkt[k]),
      .head  (head[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // Each head names a single destination, so no input can win two outputs at once.
  always_comb begin
    logic  found;
    port_t cand;
    pop      = '0;
    rr_next  = rr;
    out_next = '0;
    found    = 1'b0;
    cand     = '0;
    for (int j = 0; j < PORTS; j++) begin
      found = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
        cand = rr[j] + port_t'(i);
        if (!found && !empty[cand] && dst_of(head[cand]) == port_t'(j)) begin
          found       = 1'b1;
          pop[cand]   = 1'b1;
          out_next[j] = head[cand];
          rr_next[j]  = cand + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pkt <= '0;
      ovf     <= '0;
      rr      <= '0;
    end else begin
      out_pkt <= out_next;
      ovf     <= ovf | drop;
      rr      <= rr_next;
    end
  end

endmodule
